fse_lms_tap_updater: RTL and testbench
======================================

Name: fse_lms_tap_updater

Overview:
- Produces the coefficient bus for the fractionally spaced equalizer: packed I/Q taps plus a one-cycle tap-load strobe.
- Mirrors the equalizer's input delay line and accepts one complex error per symbol.
- Runs a complex LMS update serially, one tap per clock, then publishes the whole tap set atomically.
- Sits beside the equalizer in the RX chain; error comes from the slicer (decision minus equalizer output).

Parameters:
NUM_TAPS, 9, number of complex taps / regressor depth
NBT_IN, 8, sample width, S(8,7)
NBF_IN, 7, sample fractional bits
NBT_ERR, 12, error width, S(12,9)
NBF_ERR, 9, error fractional bits
NBT_TAPS, 28, tap width, S(28,25)
NBF_TAPS, 25, tap fractional bits
MU_SHIFT, 9, step size mu = 2^-MU_SHIFT

Ports:
clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_is_data_I  in  NBT_IN  input sample I, same stream the equalizer sees
i_is_data_Q  in  NBT_IN  input sample Q
i_ctrl  in  1  sample strobe; shifts the regressor line (rate 2)
i_err_I  in  NBT_ERR  error I = decision - y
i_err_Q  in  NBT_ERR  error Q
i_err_valid  in  1  one-cycle error strobe, one per symbol
i_en_adapt  in  1  adaptation enable
o_taps_I  out  NUM_TAPS*NBT_TAPS  packed taps I; tap k occupies bits [(k+1)*NBT_TAPS-1 : k*NBT_TAPS]
o_taps_Q  out  NUM_TAPS*NBT_TAPS  packed taps Q, same packing
o_en_taps  out  1  one-cycle strobe: new tap set valid
o_busy  out  1  update in progress

Behaviour:
- Reset (async, i_reset_n=0):
  - regressor line = 0.
  - Working taps and published taps: I[NUM_TAPS/2] = 1.0 (bit NBF_TAPS set), all other I taps = 0, all Q taps = 0.
  - State IDLE; o_en_taps = 0, o_busy = 0.
- Regressor line:
  - Shifts only on i_ctrl=1: x[0] <= input, x[k] <= x[k-1]. Otherwise holds.
  - Shifts regardless of state and regardless of i_en_adapt.
- FSM states IDLE, UPDATE, PUBLISH.
  - IDLE -> UPDATE when i_err_valid=1 and i_en_adapt=1. On the same edge, snapshot the regressor and the error; k=0.
  - If i_ctrl also fires that cycle, the snapshot takes the pre-shift contents.
  - UPDATE: one tap per cycle, k=0..NUM_TAPS-1. After k=NUM_TAPS-1 go to PUBLISH.
  - PUBLISH: copy working taps to the o_taps registers; o_en_taps=1 for exactly this cycle; return to IDLE.
- Latency: i_err_valid sampled at edge t; o_en_taps high in cycle t+NUM_TAPS+1.
- o_busy = 1 in UPDATE and PUBLISH.
- i_err_valid while busy is ignored (dropped); it causes no queuing.
- Per-tap update: w_k += mu * e * conj(x_k).
  - re = eI*xI + eQ*xQ
  - im = eQ*xI - eI*xQ
  - Each product is signed full precision, width NBT_IN+NBT_ERR+1, with NBF_IN+NBF_ERR fractional bits.
- Alignment: scaled fraction F = NBF_IN+NBF_ERR+MU_SHIFT.
  - If F <= NBF_TAPS, shift left by NBF_TAPS-F.
  - Otherwise, arithmetic right shift by F-NBF_TAPS (floor).
  - With the defaults the shift is 0.
- Accumulation: tap + increment is computed one bit wider, then saturated to NBT_TAPS at max 2^(NBT_TAPS-1)-1 and min -2^(NBT_TAPS-1). No wrap.
- o_taps change only in PUBLISH. They are stable and glitch-free between strobes.
- Abort: i_en_adapt=0 during UPDATE means next state IDLE, no o_en_taps, and working taps reloaded from the published taps.
- i_en_adapt=0 in IDLE holds all taps. It does not reset them.
- Reset mid-update: everything returns to reset values immediately; no strobe.

Test Plan:
1. Reset, then idle -> o_taps_I tap4 = 33554432 (1.0), all other taps 0, o_en_taps=0, o_busy=0.
2. Shift in x=(64,0) (0.5) so it sits at x[0] only, pulse err=(256,0) (0.5) at edge t -> o_en_taps at t+10; tap0 I = 16384, tap0 Q = 0; tap4 I unchanged.
3. Same with x=(0,64), err=(256,0) -> tap0 Q = -16384, tap0 I = 0.
4. x=(-128,-128) at x[0], err=(-2048,-2048), repeated 257 times:
   - tap0 I increments by 524288 per update.
   - It saturates at 134217727 and stays there.
   - tap0 Q stays 0.
5. Second i_err_valid 3 cycles after the first -> ignored; exactly one o_en_taps. i_ctrl pulsed together with i_err_valid -> update uses the pre-shift regressor.
6. Drop i_en_adapt mid-UPDATE -> no strobe, o_taps unchanged, next update starts from the published taps. Assert i_reset_n=0 mid-UPDATE -> reset values immediately.

Source files
------------

// File: rtl/fse_lms_tap_updater_if.sv
// Coefficient-update bus between the FSE tap updater and its surroundings:
// regressor samples, slicer error, adaptation control and the published tap set.
interface fse_lms_tap_updater_if #(
    parameter int NUM_TAPS = 9,
    parameter int NBT_IN   = 8,
    parameter int NBT_ERR  = 12,
    parameter int NBT_TAPS = 28
);
    logic signed [NBT_IN-1:0]      i_is_data_I;
    logic signed [NBT_IN-1:0]      i_is_data_Q;
    logic                          i_ctrl;
    logic signed [NBT_ERR-1:0]     i_err_I;
    logic signed [NBT_ERR-1:0]     i_err_Q;
    logic                          i_err_valid;
    logic                          i_en_adapt;
    logic [NUM_TAPS*NBT_TAPS-1:0]  o_taps_I;
    logic [NUM_TAPS*NBT_TAPS-1:0]  o_taps_Q;
    logic                          o_en_taps;
    logic                          o_busy;

    modport master (
        output i_is_data_I, i_is_data_Q, i_ctrl, i_err_I, i_err_Q, i_err_valid, i_en_adapt,
        input  o_taps_I, o_taps_Q, o_en_taps, o_busy
    );

    modport slave (
        input  i_is_data_I, i_is_data_Q, i_ctrl, i_err_I, i_err_Q, i_err_valid, i_en_adapt,
        output o_taps_I, o_taps_Q, o_en_taps, o_busy
    );
endinterface

// File: rtl/fse_lms_tap_updater.sv
// Serial complex LMS tap updater for the fractionally spaced equalizer:
// one tap per clock, whole tap set published atomically with a one-cycle strobe.
module fse_lms_tap_updater #(
    parameter int NUM_TAPS = 9,
    parameter int NBT_IN   = 8,
    parameter int NBF_IN   = 7,
    parameter int NBT_ERR  = 12,
    parameter int NBF_ERR  = 9,
    parameter int NBT_TAPS = 28,
    parameter int NBF_TAPS = 25,
    parameter int MU_SHIFT = 9
) (
    input  logic                 clk,
    input  logic                 i_reset_n,
    fse_lms_tap_updater_if.slave bus
);

    localparam int PROD_W = NBT_IN + NBT_ERR + 1;
    localparam int INC_W  = NBT_TAPS + 1;
    localparam int SUM_W  = NBT_TAPS + 2;
    localparam int F_SCL  = NBF_IN + NBF_ERR + MU_SHIFT;
    localparam int SHL    = (F_SCL <= NBF_TAPS) ? (NBF_TAPS - F_SCL) : 0;
    localparam int SHR    = (F_SCL >  NBF_TAPS) ? (F_SCL - NBF_TAPS) : 0;
    localparam int K_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int CENTER = NUM_TAPS / 2;

    localparam logic [K_W-1:0] LAST_K = K_W'(NUM_TAPS - 1);
    localparam logic signed [NBT_TAPS-1:0] TAP_ONE =
        {{(NBT_TAPS-NBF_TAPS-1){1'b0}}, 1'b1, {NBF_TAPS{1'b0}}};
    localparam logic signed [SUM_W-1:0] TAP_MAX =
        {{(SUM_W-NBT_TAPS+1){1'b0}}, {(NBT_TAPS-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] TAP_MIN =
        {{(SUM_W-NBT_TAPS+1){1'b1}}, {(NBT_TAPS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, UPDATE, PUBLISH} state_t;

    state_t state, state_nxt;
    logic [K_W-1:0] k;

    logic signed [NBT_IN-1:0]   x_I [NUM_TAPS];
    logic signed [NBT_IN-1:0]   x_Q [NUM_TAPS];
    logic signed [NBT_IN-1:0]   snap_x_I_p0 [NUM_TAPS];
    logic signed [NBT_IN-1:0]   snap_x_Q_p0 [NUM_TAPS];
    logic signed [NBT_ERR-1:0]  err_I_p0;
    logic signed [NBT_ERR-1:0]  err_Q_p0;
    logic signed [NBT_TAPS-1:0] w_I [NUM_TAPS];
    logic signed [NBT_TAPS-1:0] w_Q [NUM_TAPS];
    logic signed [NBT_TAPS-1:0] pub_I [NUM_TAPS];
    logic signed [NBT_TAPS-1:0] pub_Q [NUM_TAPS];

    logic signed [NBT_IN-1:0]   xk_I, xk_Q;
    logic signed [PROD_W-1:0]   xk_I_ext, xk_Q_ext, e_I_ext, e_Q_ext;
    logic signed [PROD_W-1:0]   prod_re, prod_im;
    logic signed [INC_W-1:0]    inc_re, inc_im;
    logic signed [NBT_TAPS-1:0] wk_I, wk_Q, new_I, new_Q;
    logic                       start;

    function automatic logic signed [INC_W-1:0] align_inc(input logic signed [PROD_W-1:0] p);
        logic signed [INC_W-1:0] ext;
        ext = {{(INC_W-PROD_W){p[PROD_W-1]}}, p};
        return (ext <<< SHL) >>> SHR;
    endfunction

    function automatic logic signed [NBT_TAPS-1:0] sat_tap(input logic signed [NBT_TAPS-1:0] w,
                                                         input logic signed [INC_W-1:0] inc);
        logic signed [SUM_W-1:0] sum;
        sum = {{(SUM_W-NBT_TAPS){w[NBT_TAPS-1]}}, w} + {{(SUM_W-INC_W){inc[INC_W-1]}}, inc};
        if (sum > TAP_MAX)      return TAP_MAX[NBT_TAPS-1:0];
        else if (sum < TAP_MIN) return TAP_MIN[NBT_TAPS-1:0];
        else                    return sum[NBT_TAPS-1:0];
    endfunction

    assign start = (state == IDLE) && bus.i_err_valid && bus.i_en_adapt;

    // Regressor line mirrors the equalizer delay line, independent of the FSM.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int j = 0; j < NUM_TAPS; j++) begin
                x_I[j] <= '0;
                x_Q[j] <= '0;
            end
        end else if (bus.i_ctrl) begin
            x_I[0] <= bus.i_is_data_I;
            x_Q[0] <= bus.i_is_data_Q;
            for (int j = 1; j < NUM_TAPS; j++) begin
                x_I[j] <= x_I[j-1];
                x_Q[j] <= x_Q[j-1];
            end
        end
    end

    // Stage p0: snapshot of regressor (pre-shift) and error for the whole update.
    always_ff @(posedge clk) begin
        if (start) begin
            snap_x_I_p0 <= x_I;
            snap_x_Q_p0 <= x_Q;
            err_I_p0    <= bus.i_err_I;
            err_Q_p0    <= bus.i_err_Q;
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_nxt;
            k     <= (state == UPDATE) ? k + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = UPDATE;
            UPDATE: begin
                if (!bus.i_en_adapt)  state_nxt = IDLE;
                else if (k == LAST_K) state_nxt = PUBLISH;
            end
            PUBLISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: w_k += mu * e * conj(x_k), one tap per clock.
    assign xk_I     = snap_x_I_p0[k];
    assign xk_Q     = snap_x_Q_p0[k];
    assign wk_I     = w_I[k];
    assign wk_Q     = w_Q[k];
    assign xk_I_ext = {{(PROD_W-NBT_IN){xk_I[NBT_IN-1]}}, xk_I};
    assign xk_Q_ext = {{(PROD_W-NBT_IN){xk_Q[NBT_IN-1]}}, xk_Q};
    assign e_I_ext  = {{(PROD_W-NBT_ERR){err_I_p0[NBT_ERR-1]}}, err_I_p0};
    assign e_Q_ext  = {{(PROD_W-NBT_ERR){err_Q_p0[NBT_ERR-1]}}, err_Q_p0};
    assign prod_re  = e_I_ext * xk_I_ext + e_Q_ext * xk_Q_ext;
    assign prod_im  = e_Q_ext * xk_I_ext - e_I_ext * xk_Q_ext;
    assign inc_re   = align_inc(prod_re);
    assign inc_im   = align_inc(prod_im);
    assign new_I    = sat_tap(wk_I, inc_re);
    assign new_Q    = sat_tap(wk_Q, inc_im);

    // The published set is loaded on the edge entering PUBLISH, so the bus
    // already carries the new taps while the strobe is high.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int j = 0; j < NUM_TAPS; j++) begin
                w_I[j]   <= (j == CENTER) ? TAP_ONE : '0;
                w_Q[j]   <= '0;
                pub_I[j] <= (j == CENTER) ? TAP_ONE : '0;
                pub_Q[j] <= '0;
            end
        end else if (state == UPDATE) begin
            if (!bus.i_en_adapt) begin
                w_I <= pub_I;
                w_Q <= pub_Q;
            end else begin
                w_I[k] <= new_I;
                w_Q[k] <= new_Q;
                if (k == LAST_K) begin
                    for (int j = 0; j < NUM_TAPS; j++) begin
                        pub_I[j] <= (j == NUM_TAPS - 1) ? new_I : w_I[j];
                        pub_Q[j] <= (j == NUM_TAPS - 1) ? new_Q : w_Q[j];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_pack
        assign bus.o_taps_I[g*NBT_TAPS +: NBT_TAPS] = pub_I[g];
        assign bus.o_taps_Q[g*NBT_TAPS +: NBT_TAPS] = pub_Q[g];
    end

    assign bus.o_en_taps = (state == PUBLISH);
    assign bus.o_busy    = (state != IDLE);

endmodule

// File: tb/tb_fse_lms_tap_updater.sv
// Scoreboard bench for fse_lms_tap_updater: a complex LMS model predicts each
// published tap set, which is checked when the tap-load strobe appears.
module tb_fse_lms_tap_updater;

    localparam int NUM_TAPS = 9;
    localparam int NBT_IN   = 8;
    localparam int NBF_IN   = 7;
    localparam int NBT_ERR  = 12;
    localparam int NBF_ERR  = 9;
    localparam int NBT_TAPS = 28;
    localparam int NBF_TAPS = 25;
    localparam int MU_SHIFT = 9;
    localparam int LAT      = NUM_TAPS + 1;
    localparam int BUS_W    = NUM_TAPS * NBT_TAPS;
    localparam int F_SCL    = NBF_IN + NBF_ERR + MU_SHIFT;
    localparam longint TAP_MAX = (longint'(1) << (NBT_TAPS - 1)) - 1;
    localparam longint TAP_MIN = -(longint'(1) << (NBT_TAPS - 1));

    logic clk = 1'b0;
    logic i_reset_n = 1'b0;

    fse_lms_tap_updater_if #(.NUM_TAPS(NUM_TAPS), .NBT_IN(NBT_IN), .NBT_ERR(NBT_ERR),
                             .NBT_TAPS(NBT_TAPS)) bus ();

    fse_lms_tap_updater #(.NUM_TAPS(NUM_TAPS), .NBT_IN(NBT_IN), .NBF_IN(NBF_IN),
                          .NBT_ERR(NBT_ERR), .NBF_ERR(NBF_ERR), .NBT_TAPS(NBT_TAPS),
                          .NBF_TAPS(NBF_TAPS), .MU_SHIFT(MU_SHIFT))
        dut (.clk(clk), .i_reset_n(i_reset_n), .bus(bus));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int strobe_cnt = 0;
    logic [BUS_W-1:0] exp_q_I[$];
    logic [BUS_W-1:0] exp_q_Q[$];
    longint m_x_I[NUM_TAPS];
    longint m_x_Q[NUM_TAPS];
    longint m_w_I[NUM_TAPS];
    longint m_w_Q[NUM_TAPS];

    always @(negedge clk) if (bus.o_en_taps === 1'b1) strobe_cnt <= strobe_cnt + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic longint sat(input longint v);
        if (v > TAP_MAX) return TAP_MAX;
        if (v < TAP_MIN) return TAP_MIN;
        return v;
    endfunction

    function automatic logic [BUS_W-1:0] pack_taps(input bit q);
        logic [BUS_W-1:0] p;
        for (int j = 0; j < NUM_TAPS; j++)
            p[j*NBT_TAPS +: NBT_TAPS] = q ? m_w_Q[j][NBT_TAPS-1:0] : m_w_I[j][NBT_TAPS-1:0];
        return p;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < NUM_TAPS; j++) begin
            m_x_I[j] = 0;
            m_x_Q[j] = 0;
            m_w_I[j] = (j == NUM_TAPS / 2) ? (longint'(1) << NBF_TAPS) : 0;
            m_w_Q[j] = 0;
        end
        exp_q_I.delete();
        exp_q_Q.delete();
    endtask

    task automatic model_shift(input longint xi, input longint xq);
        for (int j = NUM_TAPS - 1; j > 0; j--) begin
            m_x_I[j] = m_x_I[j-1];
            m_x_Q[j] = m_x_Q[j-1];
        end
        m_x_I[0] = xi;
        m_x_Q[0] = xq;
    endtask

    task automatic model_update(input longint ei, input longint eq);
        longint re, im;
        for (int j = 0; j < NUM_TAPS; j++) begin
            re = ei * m_x_I[j] + eq * m_x_Q[j];
            im = eq * m_x_I[j] - ei * m_x_Q[j];
            if (F_SCL <= NBF_TAPS) begin
                re = re <<< (NBF_TAPS - F_SCL);
                im = im <<< (NBF_TAPS - F_SCL);
            end else begin
                re = re >>> (F_SCL - NBF_TAPS);
                im = im >>> (F_SCL - NBF_TAPS);
            end
            m_w_I[j] = sat(m_w_I[j] + re);
            m_w_Q[j] = sat(m_w_Q[j] + im);
        end
        exp_q_I.push_back(pack_taps(1'b0));
        exp_q_Q.push_back(pack_taps(1'b1));
    endtask

    task automatic apply_reset();
        i_reset_n = 1'b0;
        bus.i_is_data_I = '0;
        bus.i_is_data_Q = '0;
        bus.i_ctrl      = 1'b0;
        bus.i_err_I     = '0;
        bus.i_err_Q     = '0;
        bus.i_err_valid = 1'b0;
        bus.i_en_adapt  = 1'b1;
        tick();
        tick();
        i_reset_n = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic shift_in(input int xi, input int xq);
        bus.i_is_data_I = NBT_IN'(xi);
        bus.i_is_data_Q = NBT_IN'(xq);
        bus.i_ctrl = 1'b1;
        tick();
        bus.i_ctrl = 1'b0;
        model_shift(xi, xq);
    endtask

    // Drives one error strobe and waits (bounded) for the tap-load strobe; lat=-1 on timeout.
    task automatic run_update(input int ei, input int eq, input bit with_ctrl,
                              input int xi, input int xq, output int lat);
        bus.i_err_I = NBT_ERR'(ei);
        bus.i_err_Q = NBT_ERR'(eq);
        bus.i_err_valid = 1'b1;
        if (with_ctrl) begin
            bus.i_is_data_I = NBT_IN'(xi);
            bus.i_is_data_Q = NBT_IN'(xq);
            bus.i_ctrl = 1'b1;
        end
        model_update(ei, eq);
        if (with_ctrl) model_shift(xi, xq);
        tick();
        bus.i_err_valid = 1'b0;
        bus.i_ctrl = 1'b0;
        lat = 1;
        while (bus.o_en_taps !== 1'b1 && lat < 4 * LAT) begin
            tick();
            lat++;
        end
        if (bus.o_en_taps !== 1'b1) lat = -1;
    endtask

    function automatic longint tap_of(input logic [BUS_W-1:0] b, input int idx);
        logic signed [NBT_TAPS-1:0] t;
        t = b[idx*NBT_TAPS +: NBT_TAPS];
        return longint'(t);
    endfunction

    task automatic test_reset();
        int c0;
        apply_reset();
        tests++;
        if (tap_of(bus.o_taps_I, 4) !== 33554432) begin
            fails++; $display("FAIL reset_tap4_I: got %0d expected 33554432", tap_of(bus.o_taps_I, 4));
        end
        tests++;
        if (bus.o_taps_I !== pack_taps(1'b0)) begin
            fails++; $display("FAIL reset_taps_I: got %h expected %h", bus.o_taps_I, pack_taps(1'b0));
        end
        tests++;
        if (bus.o_taps_Q !== pack_taps(1'b1)) begin
            fails++; $display("FAIL reset_taps_Q: got %h expected %h", bus.o_taps_Q, pack_taps(1'b1));
        end
        tests++;
        if (bus.o_en_taps !== 1'b0 || bus.o_busy !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl: got en=%b busy=%b expected en=0 busy=0", bus.o_en_taps, bus.o_busy);
        end
        c0 = strobe_cnt;
        bus.i_en_adapt = 1'b0;
        bus.i_err_I = 12'sd256;
        bus.i_err_valid = 1'b1;
        tick();
        bus.i_err_valid = 1'b0;
        tests++;
        if (bus.o_busy !== 1'b0) begin
            fails++; $display("FAIL noadapt_busy: got %b expected 0", bus.o_busy);
        end
        repeat (2 * LAT) tick();
        bus.i_en_adapt = 1'b1;
        tests++;
        if (strobe_cnt - c0 !== 0 || bus.o_taps_I !== pack_taps(1'b0)) begin
            fails++; $display("FAIL noadapt_hold: got strobes=%0d taps=%h expected strobes=0 taps=%h",
                              strobe_cnt - c0, bus.o_taps_I, pack_taps(1'b0));
        end
    endtask

    task automatic test_update_I();
        int lat;
        logic [BUS_W-1:0] eI, eQ;
        apply_reset();
        shift_in(64, 0);
        run_update(256, 0, 1'b0, 0, 0, lat);
        tests++;
        if (lat !== LAT) begin fails++; $display("FAIL upd_I_latency: got %0d expected %0d", lat, LAT); end
        tests++;
        if (exp_q_I.size() == 0) begin
            fails++; $display("FAIL upd_I_sb: got 0 entries expected 1");
        end else begin
            eI = exp_q_I.pop_front();
            eQ = exp_q_Q.pop_front();
            if (bus.o_taps_I !== eI || bus.o_taps_Q !== eQ) begin
                fails++; $display("FAIL upd_I_taps: got I=%h Q=%h expected I=%h Q=%h", bus.o_taps_I, bus.o_taps_Q, eI, eQ);
            end
        end
        tests++;
        if (tap_of(bus.o_taps_I, 0) !== 16384 || tap_of(bus.o_taps_Q, 0) !== 0 || tap_of(bus.o_taps_I, 4) !== 33554432) begin
            fails++; $display("FAIL upd_I_tap0: got I0=%0d Q0=%0d I4=%0d expected 16384 0 33554432",
                              tap_of(bus.o_taps_I, 0), tap_of(bus.o_taps_Q, 0), tap_of(bus.o_taps_I, 4));
        end
        tick();
        tests++;
        if (bus.o_en_taps !== 1'b0 || bus.o_busy !== 1'b0) begin
            fails++; $display("FAIL upd_I_strobe_width: got en=%b busy=%b expected 0 0", bus.o_en_taps, bus.o_busy);
        end
    endtask

    task automatic test_update_Q();
        int lat;
        logic [BUS_W-1:0] eI, eQ;
        apply_reset();
        shift_in(0, 64);
        run_update(256, 0, 1'b0, 0, 0, lat);
        tests++;
        if (lat !== LAT) begin fails++; $display("FAIL upd_Q_latency: got %0d expected %0d", lat, LAT); end
        tests++;
        if (exp_q_I.size() == 0) begin
            fails++; $display("FAIL upd_Q_sb: got 0 entries expected 1");
        end else begin
            eI = exp_q_I.pop_front();
            eQ = exp_q_Q.pop_front();
            if (bus.o_taps_I !== eI || bus.o_taps_Q !== eQ) begin
                fails++; $display("FAIL upd_Q_taps: got I=%h Q=%h expected I=%h Q=%h", bus.o_taps_I, bus.o_taps_Q, eI, eQ);
            end
        end
        tests++;
        if (tap_of(bus.o_taps_Q, 0) !== -16384 || tap_of(bus.o_taps_I, 0) !== 0) begin
            fails++; $display("FAIL upd_Q_tap0: got Q0=%0d I0=%0d expected -16384 0",
                              tap_of(bus.o_taps_Q, 0), tap_of(bus.o_taps_I, 0));
        end
        tick();
    endtask

    task automatic test_saturation();
        int lat;
        logic [BUS_W-1:0] eI, eQ;
        apply_reset();
        shift_in(-128, -128);
        for (int i = 0; i < 257; i++) begin
            run_update(-2048, -2048, 1'b0, 0, 0, lat);
            tests++;
            if (lat !== LAT) begin fails++; $display("FAIL sat_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
            tests++;
            if (exp_q_I.size() == 0) begin
                fails++; $display("FAIL sat_sb[%0d]: got 0 entries expected 1", i);
            end else begin
                eI = exp_q_I.pop_front();
                eQ = exp_q_Q.pop_front();
                if (bus.o_taps_I !== eI || bus.o_taps_Q !== eQ) begin
                    fails++; $display("FAIL sat_taps[%0d]: got I0=%0d Q0=%0d expected I0=%0d Q0=%0d", i,
                                      tap_of(bus.o_taps_I, 0), tap_of(bus.o_taps_Q, 0), tap_of(eI, 0), tap_of(eQ, 0));
                end
            end
            if (i == 0) begin
                tests++;
                if (tap_of(bus.o_taps_I, 0) !== 524288) begin
                    fails++; $display("FAIL sat_first_step: got %0d expected 524288", tap_of(bus.o_taps_I, 0));
                end
            end
            tick();
        end
        tests++;
        if (tap_of(bus.o_taps_I, 0) !== 134217727 || tap_of(bus.o_taps_Q, 0) !== 0) begin
            fails++; $display("FAIL sat_final: got I0=%0d Q0=%0d expected 134217727 0",
                              tap_of(bus.o_taps_I, 0), tap_of(bus.o_taps_Q, 0));
        end
    endtask

    task automatic test_back_to_back();
        int c0, lat;
        logic [BUS_W-1:0] eI, eQ;
        apply_reset();
        shift_in(64, 0);
        c0 = strobe_cnt;
        bus.i_err_I = 12'sd256;
        bus.i_err_Q = 12'sd0;
        bus.i_err_valid = 1'b1;
        model_update(256, 0);
        tick();
        bus.i_err_valid = 1'b0;
        tick();
        tick();
        bus.i_err_I = 12'sd100;
        bus.i_err_Q = -12'sd50;
        bus.i_err_valid = 1'b1;
        tests++;
        if (bus.o_busy !== 1'b1) begin fails++; $display("FAIL b2b_busy: got %b expected 1", bus.o_busy); end
        tick();
        bus.i_err_valid = 1'b0;
        lat = 4;
        while (bus.o_en_taps !== 1'b1 && lat < 4 * LAT) begin tick(); lat++; end
        tests++;
        if (lat !== LAT) begin fails++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT); end
        tests++;
        if (exp_q_I.size() == 0) begin
            fails++; $display("FAIL b2b_sb: got 0 entries expected 1");
        end else begin
            eI = exp_q_I.pop_front();
            eQ = exp_q_Q.pop_front();
            if (bus.o_taps_I !== eI || bus.o_taps_Q !== eQ) begin
                fails++; $display("FAIL b2b_taps: got I=%h Q=%h expected I=%h Q=%h", bus.o_taps_I, bus.o_taps_Q, eI, eQ);
            end
        end
        repeat (2 * LAT) tick();
        tests++;
        if (strobe_cnt - c0 !== 1) begin
            fails++; $display("FAIL b2b_strobes: got %0d expected 1", strobe_cnt - c0);
        end
        run_update(256, 0, 1'b1, -128, 0, lat);
        tests++;
        if (exp_q_I.size() == 0) begin
            fails++; $display("FAIL preshift_sb: got 0 entries expected 1");
        end else begin
            eI = exp_q_I.pop_front();
            eQ = exp_q_Q.pop_front();
            if (bus.o_taps_I !== eI || bus.o_taps_Q !== eQ) begin
                fails++; $display("FAIL preshift_taps: got I=%h Q=%h expected I=%h Q=%h", bus.o_taps_I, bus.o_taps_Q, eI, eQ);
            end
        end
        tests++;
        if (tap_of(bus.o_taps_I, 0) !== 32768 || tap_of(bus.o_taps_I, 1) !== 0) begin
            fails++; $display("FAIL preshift_tap01: got I0=%0d I1=%0d expected 32768 0",
                              tap_of(bus.o_taps_I, 0), tap_of(bus.o_taps_I, 1));
        end
        tick();
    endtask

    task automatic test_abort_and_reset();
        int c0, lat;
        logic [BUS_W-1:0] eI, eQ;
        apply_reset();
        shift_in(64, 0);
        run_update(256, 0, 1'b0, 0, 0, lat);
        tests++;
        if (exp_q_I.size() == 0) begin
            fails++; $display("FAIL abort_pre_sb: got 0 entries expected 1");
        end else begin
            eI = exp_q_I.pop_front();
            eQ = exp_q_Q.pop_front();
            if (bus.o_taps_I !== eI || bus.o_taps_Q !== eQ) begin
                fails++; $display("FAIL abort_pre_taps: got I=%h Q=%h expected I=%h Q=%h", bus.o_taps_I, bus.o_taps_Q, eI, eQ);
            end
        end
        tick();
        c0 = strobe_cnt;
        bus.i_err_valid = 1'b1;
        tick();
        bus.i_err_valid = 1'b0;
        repeat (3) tick();
        bus.i_en_adapt = 1'b0;
        tick();
        tests++;
        if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", bus.o_busy); end
        bus.i_en_adapt = 1'b1;
        repeat (2 * LAT) tick();
        tests++;
        if (strobe_cnt - c0 !== 0 || bus.o_taps_I !== pack_taps(1'b0)) begin
            fails++; $display("FAIL abort_hold: got strobes=%0d taps=%h expected strobes=0 taps=%h",
                              strobe_cnt - c0, bus.o_taps_I, pack_taps(1'b0));
        end
        run_update(256, 0, 1'b0, 0, 0, lat);
        tests++;
        if (exp_q_I.size() == 0) begin
            fails++; $display("FAIL abort_post_sb: got 0 entries expected 1");
        end else begin
            eI = exp_q_I.pop_front();
            eQ = exp_q_Q.pop_front();
            if (bus.o_taps_I !== eI || bus.o_taps_Q !== eQ) begin
                fails++; $display("FAIL abort_post_taps: got I0=%0d expected I0=%0d", tap_of(bus.o_taps_I, 0), tap_of(eI, 0));
            end
        end
        tests++;
        if (tap_of(bus.o_taps_I, 0) !== 32768) begin
            fails++; $display("FAIL abort_post_tap0: got %0d expected 32768", tap_of(bus.o_taps_I, 0));
        end
        tick();
        c0 = strobe_cnt;
        bus.i_err_valid = 1'b1;
        tick();
        bus.i_err_valid = 1'b0;
        repeat (2) tick();
        i_reset_n = 1'b0;
        #1;
        model_reset();
        tests++;
        if (bus.o_busy !== 1'b0 || bus.o_en_taps !== 1'b0) begin
            fails++; $display("FAIL midreset_ctrl: got busy=%b en=%b expected 0 0", bus.o_busy, bus.o_en_taps);
        end
        tests++;
        if (bus.o_taps_I !== pack_taps(1'b0) || bus.o_taps_Q !== pack_taps(1'b1)) begin
            fails++; $display("FAIL midreset_taps: got I=%h Q=%h expected I=%h Q=%h",
                              bus.o_taps_I, bus.o_taps_Q, pack_taps(1'b0), pack_taps(1'b1));
        end
        tick();
        i_reset_n = 1'b1;
        repeat (2 * LAT) tick();
        tests++;
        if (strobe_cnt - c0 !== 0 || bus.o_busy !== 1'b0) begin
            fails++; $display("FAIL midreset_quiet: got strobes=%0d busy=%b expected 0 0", strobe_cnt - c0, bus.o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_update_I();
        test_update_Q();
        test_saturation();
        test_back_to_back();
        test_abort_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
